// File: rtl/nway_cache.sv
// nway_cache: N-way set-associative write-back/write-allocate cache, 32-bit CPU port to line-wide memory.
// Latency: a hit responds one cycle after the request; a miss adds optional writeback, the fill, and two cycles.
// Backpressure: CPU request is held until mem_resp; memory requests are held until pmem_resp, no other stalls.
module nway_cache #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_way    = 2,
   parameter int s_tag    = 32 - s_offset - s_index
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [3:0]                   mem_byte_enable,
   input  logic [31:0]                  mem_address,
   input  logic [31:0]                  mem_wdata,
   output logic                         mem_resp,
   output logic [31:0]                  mem_rdata,
   input  logic                         pmem_resp,
   input  logic [8*(2**s_offset)-1:0]   pmem_rdata,
   output logic [8*(2**s_offset)-1:0]   pmem_wdata,
   output logic                         pmem_read,
   output logic                         pmem_write,
   output logic [31:0]                  pmem_address
);

   localparam int line_w   = 8 * (2**s_offset);
   localparam int num_sets = 2**s_index;
   localparam int num_ways = 2**s_way;
   localparam int way_w    = (s_way > 0) ? s_way : 1;
   localparam int plru_w   = (num_ways > 1) ? num_ways - 1 : 1;
   localparam int pidx_w   = (plru_w > 1) ? $clog2(plru_w) : 1;

   typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

   state_t state, state_n;

   // Storage: valid/dirty/PLRU carry reset, tags and lines do not need it.
   logic [num_ways-1:0] valid_arr [num_sets];
   logic [num_ways-1:0] dirty_arr [num_sets];
   logic [plru_w-1:0]   plru_arr  [num_sets];
   logic [s_tag-1:0]    tag_arr   [num_sets][num_ways];
   logic [line_w-1:0]   data_arr  [num_sets][num_ways];

   logic [s_index-1:0]  index;
   logic [s_tag-1:0]    tag;
   logic [s_offset-3:0] wsel;
   logic                unused_addr_bits;

   logic                hit;
   logic [way_w-1:0]    hit_way;
   logic [way_w-1:0]    victim;
   logic [way_w-1:0]    victim_q;
   logic                vic_found;
   logic                vic_bit;
   logic [pidx_w-1:0]   vic_node;
   logic [plru_w-1:0]   plru_upd;
   logic [pidx_w-1:0]   upd_node;
   logic [way_w-1:0]    upd_shift;
   logic                upd_dir;
   logic [line_w-1:0]   hit_line;
   logic [line_w-1:0]   merged_line;
   logic                hit_we;
   logic                fill_we;
   logic                word_write;

   assign index            = mem_address[s_offset +: s_index];
   assign tag              = mem_address[31 -: s_tag];
   assign wsel             = mem_address[s_offset-1:2];
   assign unused_addr_bits = ^mem_address[1:0];
   assign word_write       = mem_write && (mem_byte_enable != 4'b0000);

   // Tag compare across all ways of the addressed set; at most one way can match.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < num_ways; w++) begin
         if (valid_arr[index][w] && (tag_arr[index][w] == tag)) begin
            hit     = 1'b1;
            hit_way = way_w'(w);
         end
      end
   end

   // Victim choice: lowest invalid way first, otherwise walk the PLRU tree (bit 0 = lower half).
   always_comb begin
      vic_found = 1'b0;
      victim    = '0;
      vic_node  = '0;
      vic_bit   = 1'b0;
      for (int w = 0; w < num_ways; w++) begin
         if (!vic_found && !valid_arr[index][w]) begin
            vic_found = 1'b1;
            victim    = way_w'(w);
         end
      end
      if (!vic_found) begin
         for (int l = 0; l < s_way; l++) begin
            vic_bit  = plru_arr[index][vic_node];
            victim   = way_w'({victim, vic_bit});
            vic_node = pidx_w'(2 * vic_node + 1 + (vic_bit ? 1 : 0));
         end
      end
   end

   // PLRU update for the hit way: every node on its path is turned to point away from it.
   always_comb begin
      plru_upd  = plru_arr[index];
      upd_node  = '0;
      upd_shift = '0;
      upd_dir   = 1'b0;
      for (int l = 0; l < s_way; l++) begin
         upd_shift          = hit_way >> (s_way - 1 - l);
         upd_dir            = upd_shift[0];
         plru_upd[upd_node] = ~upd_dir;
         upd_node           = pidx_w'(2 * upd_node + 1 + (upd_dir ? 1 : 0));
      end
   end

   // Hit line readout and byte-lane merge of the CPU write word.
   always_comb begin
      hit_line    = data_arr[index][hit_way];
      merged_line = hit_line;
      for (int b = 0; b < 4; b++) begin
         if (mem_byte_enable[b]) begin
            merged_line[wsel*32 + b*8 +: 8] = mem_wdata[b*8 +: 8];
         end
      end
   end

   // Next state and all outputs; outputs are zero whenever the state does not drive them.
   always_comb begin
      state_n      = state;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      hit_we       = 1'b0;
      fill_we      = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read || mem_write) state_n = CHECK;
         end
         CHECK: begin
            if (hit) begin
               mem_resp  = 1'b1;
               mem_rdata = hit_line[wsel*32 +: 32];
               hit_we    = 1'b1;
               state_n   = IDLE;
            end else if (valid_arr[index][victim] && dirty_arr[index][victim]) begin
               state_n = WB;
            end else begin
               state_n = FILL;
            end
         end
         WB: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_arr[index][victim_q], index, {s_offset{1'b0}}};
            pmem_wdata   = data_arr[index][victim_q];
            if (pmem_resp) state_n = FILL;
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
            if (pmem_resp) begin
               fill_we = 1'b1;
               state_n = CHECK;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register; the victim is frozen on the miss so WB and FILL target the same way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         victim_q <= '0;
      end else begin
         state <= state_n;
         if (state == CHECK && !hit) victim_q <= victim;
      end
   end

   // Valid, dirty and PLRU bits: cleared on reset, updated by CHECK hits and completed fills.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < num_sets; s++) begin
            valid_arr[s] <= '0;
            dirty_arr[s] <= '0;
            plru_arr[s]  <= '0;
         end
      end else begin
         if (hit_we) begin
            plru_arr[index] <= plru_upd;
            if (word_write) dirty_arr[index][hit_way] <= 1'b1;
         end
         if (fill_we) begin
            valid_arr[index][victim_q] <= 1'b1;
            dirty_arr[index][victim_q] <= 1'b0;
         end
      end
   end

   // Tag and line storage: written by byte-enabled write hits and by fills.
   always_ff @(posedge clk) begin
      if (hit_we && word_write) data_arr[index][hit_way] <= merged_line;
      if (fill_we) begin
         data_arr[index][victim_q] <= pmem_rdata;
         tag_arr[index][victim_q]  <= tag;
      end
   end

endmodule

// File: tb/tb_nway_cache.sv
// tb_nway_cache: directed checks of the N-way cache against hand-computed results.
// Latency: memory model answers a request on the second falling edge it sees it held.
// Backpressure: CPU requests are held until mem_resp, bounded by a cycle budget per access.
module tb_nway_cache;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read, mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_address, mem_wdata;
   logic         mem_resp;
   logic [31:0]  mem_rdata;
   logic         pmem_resp;
   logic [255:0] pmem_rdata, pmem_wdata;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;

   int vectors     = 0;
   int miscompares = 0;

   logic [255:0] pmem [logic [31:0]];
   int           rd_count = 0;
   int           wr_count = 0;
   int           resp_cnt = 0;
   logic [31:0]  last_rd_addr = '0;
   logic [31:0]  last_wr_addr = '0;
   logic [255:0] last_wr_data = '0;
   logic         both_seen = 1'b0;

   always #5 clk = ~clk;

   nway_cache dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .pmem_wdata(pmem_wdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address)
   );

   // Untouched memory returns each word's own byte address.
   function automatic logic [255:0] pattern_line(input logic [31:0] a);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = a + 32'(4 * k);
      return l;
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Physical memory model, driven on the falling edge.
   always @(negedge clk) begin
      if (pmem_read && pmem_write) both_seen = 1'b1;
      if (rst) begin
         pmem_resp = 1'b0;
         resp_cnt  = 0;
      end else if (pmem_resp) begin
         pmem_resp = 1'b0;
         resp_cnt  = 0;
      end else if (pmem_read || pmem_write) begin
         resp_cnt++;
         if (resp_cnt == 2) begin
            pmem_resp = 1'b1;
            if (pmem_write) begin
               pmem[pmem_address] = pmem_wdata;
               wr_count++;
               last_wr_addr = pmem_address;
               last_wr_data = pmem_wdata;
            end else begin
               pmem_rdata = pmem.exists(pmem_address) ? pmem[pmem_address] : pattern_line(pmem_address);
               rd_count++;
               last_rd_addr = pmem_address;
            end
         end
      end
   end

   // One CPU access; lat counts falling edges up to and including the mem_resp cycle (hit = 2).
   task automatic access(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
      @(posedge clk); #1;
      mem_read = !wr; mem_write = wr; mem_address = addr; mem_byte_enable = be; mem_wdata = wd;
      lat = 0;
      rd  = 'x;
      do begin
         @(negedge clk);
         lat++;
      end while (!mem_resp && lat < 100);
      check32("resp_seen", 32'(mem_resp), 32'd1);
      if (mem_resp) rd = mem_rdata;
      @(posedge clk); #1;
      check32("resp_one_cycle", 32'(mem_resp), 32'd0);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  rd;
      int           lat, rc, wc;
      logic [255:0] l40, exp_line;

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
      mem_address = '0; mem_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
      l40 = '0;
      l40[31:0]  = 32'h1111_1111;
      l40[63:32] = 32'hAAAA_AAAA;
      l40[95:64] = 32'hDEAD_BEEF;
      pmem[32'h40] = l40;

      // Reset state of every output.
      repeat (2) @(posedge clk); #1;
      check32("rst_mem_resp", 32'(mem_resp), 32'd0);
      check32("rst_pmem_read", 32'(pmem_read), 32'd0);
      check32("rst_pmem_write", 32'(pmem_write), 32'd0);
      check32("rst_pmem_address", pmem_address, 32'd0);
      check_line("rst_pmem_wdata", pmem_wdata, 256'd0);
      check32("rst_mem_rdata", mem_rdata, 32'd0);
      rst = 1'b0;

      // Cold read: fill only.
      access(1'b0, 32'h48, 4'h0, 32'h0, rd, lat);
      check32("t1_rdata", rd, 32'hDEAD_BEEF);
      check32("t1_reads", 32'(rd_count), 32'd1);
      check32("t1_writes", 32'(wr_count), 32'd0);
      check32("t1_fill_addr", last_rd_addr, 32'h40);
      check32("t1_lat", 32'(lat), 32'd5);

      // Hits after the fill.
      access(1'b0, 32'h48, 4'h0, 32'h0, rd, lat);
      check32("t2_lat", 32'(lat), 32'd2);
      check32("t2_rdata", rd, 32'hDEAD_BEEF);
      access(1'b0, 32'h40, 4'h0, 32'h0, rd, lat);
      check32("t2_rdata_w0", rd, 32'h1111_1111);
      check32("t2_no_pmem_read", 32'(rd_count), 32'd1);

      // Partial write hit, then read back.
      access(1'b1, 32'h44, 4'b0011, 32'h1234_5678, rd, lat);
      check32("t3_wr_lat", 32'(lat), 32'd2);
      access(1'b0, 32'h44, 4'h0, 32'h0, rd, lat);
      check32("t3_rdata", rd, 32'hAAAA_5678);

      // Set 0: A, B (written -> dirty), C, D fill ways 0..3; touch A and C; E evicts B.
      access(1'b0, 32'h000, 4'h0, 32'h0, rd, lat);
      check32("t4_a", rd, 32'h000);
      access(1'b1, 32'h104, 4'hF, 32'hB0B0_B0B0, rd, lat);
      access(1'b0, 32'h200, 4'h0, 32'h0, rd, lat);
      check32("t4_c", rd, 32'h200);
      access(1'b0, 32'h300, 4'h0, 32'h0, rd, lat);
      check32("t4_d", rd, 32'h300);
      check32("t4_reads", 32'(rd_count), 32'd5);
      access(1'b0, 32'h008, 4'h0, 32'h0, rd, lat);
      check32("t4_touch_a", rd, 32'h008);
      check32("t4_touch_a_lat", 32'(lat), 32'd2);
      access(1'b0, 32'h20C, 4'h0, 32'h0, rd, lat);
      check32("t4_touch_c", rd, 32'h20C);
      wc = wr_count;
      access(1'b0, 32'h404, 4'h0, 32'h0, rd, lat);
      check32("t4_e_rdata", rd, 32'h404);
      check32("t4_e_lat", 32'(lat), 32'd8);
      check32("t4_wb_count", 32'(wr_count), 32'(wc + 1));
      check32("t4_wb_addr", last_wr_addr, 32'h100);
      exp_line = pattern_line(32'h100);
      exp_line[63:32] = 32'hB0B0_B0B0;
      check_line("t4_wb_data", last_wr_data, exp_line);
      // B returns from memory with the written word; D (clean) is the next victim.
      access(1'b0, 32'h104, 4'h0, 32'h0, rd, lat);
      check32("t4_b_back", rd, 32'hB0B0_B0B0);
      check32("t4_b_no_wb", 32'(wr_count), 32'(wc + 1));
      check32("t4_b_lat", 32'(lat), 32'd5);

      // Write with no byte lanes on a clean hit, then evict that line.
      access(1'b0, 32'h20, 4'h0, 32'h0, rd, lat);
      access(1'b1, 32'h24, 4'h0, 32'hFFFF_FFFF, rd, lat);
      check32("t5_be0_lat", 32'(lat), 32'd2);
      access(1'b0, 32'h24, 4'h0, 32'h0, rd, lat);
      check32("t5_unchanged", rd, 32'h24);
      for (int k = 1; k <= 3; k++) access(1'b0, 32'h20 + 32'(k * 256), 4'h0, 32'h0, rd, lat);
      wc = wr_count;
      rc = rd_count;
      access(1'b0, 32'h420, 4'h0, 32'h0, rd, lat);
      check32("t5_evict_rdata", rd, 32'h420);
      check32("t5_evict_no_wb", 32'(wr_count), 32'(wc));
      check32("t5_evict_read", 32'(rd_count), 32'(rc + 1));
      check32("t5_evict_lat", 32'(lat), 32'd5);

      // Dirty line at 0x40 is evicted after three more fills in set 2.
      for (int k = 1; k <= 3; k++) access(1'b0, 32'h40 + 32'(k * 256), 4'h0, 32'h0, rd, lat);
      wc = wr_count;
      access(1'b0, 32'h440, 4'h0, 32'h0, rd, lat);
      check32("t3_evict_lat", 32'(lat), 32'd8);
      check32("t3_wb_count", 32'(wr_count), 32'(wc + 1));
      check32("t3_wb_addr", last_wr_addr, 32'h40);
      exp_line = l40;
      exp_line[63:32] = 32'hAAAA_5678;
      check_line("t3_wb_data", last_wr_data, exp_line);

      // Reset in the middle of a fill.
      @(posedge clk); #1;
      mem_read = 1'b1; mem_address = 32'h60;
      lat = 0;
      while (!pmem_read && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check32("t6_fill_started", 32'(pmem_read), 32'd1);
      #1 rst = 1'b1;
      #1;
      check32("t6_pmem_read_drop", 32'(pmem_read), 32'd0);
      check32("t6_pmem_write", 32'(pmem_write), 32'd0);
      check32("t6_pmem_address", pmem_address, 32'd0);
      mem_read = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      rc = rd_count;
      access(1'b0, 32'h44, 4'h0, 32'h0, rd, lat);
      check32("t6_misses", 32'(rd_count), 32'(rc + 1));
      check32("t6_miss_lat", 32'(lat), 32'd5);
      check32("t6_rdata", rd, 32'hAAAA_5678);

      check32("rd_wr_exclusive", 32'(both_seen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
